dcache_controller: RTL

- Control stage directly upstream of the 2-way, 16-set dcache SRAM.
- Accepts 32-bit CPU load/store requests and splits the address into tag, index and offset.
- Drives the SRAM lookup, stalls the CPU on miss, writes back dirty victims, and refills 256-bit lines from data memory.
- Merges store words into lines and returns the addressed load word.

---
 rtl/dcache_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// Control stage in front of a 2-way, 16-set data cache SRAM: hit/miss handling,
// dirty-victim write-back and 256-bit line refill from data memory.
module dcache_controller #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int IDX_W  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_W-1:0]         cpu_addr_i,
    input  logic [31:0]               cpu_data_i,
    input  logic                      cpu_MemRead_i,
    input  logic                      cpu_MemWrite_i,
    output logic [31:0]               cpu_data_o,
    output logic                      cpu_stall_o,
    output logic [IDX_W-1:0]          sram_addr_o,
    output logic [ADDR_W-IDX_W-4:0]   sram_tag_o,
    output logic [LINE_W-1:0]         sram_data_o,
    output logic                      sram_enable_o,
    output logic                      sram_write_o,
    input  logic [ADDR_W-IDX_W-4:0]   sram_tag_i,
    input  logic [LINE_W-1:0]         sram_data_i,
    input  logic                      sram_hit_i,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [LINE_W-1:0]         mem_data_o,
    output logic                      mem_enable_o,
    output logic                      mem_write_o,
    input  logic [LINE_W-1:0]         mem_data_i,
    input  logic                      mem_ack_i
);

    localparam int TAG_W = ADDR_W - IDX_W - 5;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    state_t state_q, state_d;

    logic              req, is_store;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [2:0]        req_word;
    logic              victim_valid, victim_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic [ADDR_W-1:0] refill_addr, wb_addr;
    logic [LINE_W-1:0] store_line;
    logic [1:0]        tag_flags;
    logic              sram_we;
    logic              unused_addr_bits;

    assign req      = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_store = cpu_MemWrite_i;
    assign req_tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx  = cpu_addr_i[5 +: IDX_W];
    assign req_word = cpu_addr_i[4:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign victim_valid = sram_tag_i[TAG_W+1];
    assign victim_dirty = sram_tag_i[TAG_W];
    assign victim_tag   = sram_tag_i[TAG_W-1:0];
    assign refill_addr  = {req_tag, req_idx, 5'b0};
    assign wb_addr      = {victim_tag, req_idx, 5'b0};

    assign sram_enable_o = req;
    assign sram_addr_o   = req_idx;
    assign sram_tag_o    = {tag_flags, req_tag};
    assign cpu_stall_o   = req & ~((state_q == IDLE) & sram_hit_i);
    assign cpu_data_o    = sram_hit_i ? sram_data_i[{req_word, 5'b0} +: 32] : 32'd0;
    // A reset landing in a write cycle must not commit anything to the SRAM.
    assign sram_write_o  = sram_we & ~rst_i;

    always_comb begin
        store_line = sram_data_i;
        store_line[{req_word, 5'b0} +: 32] = cpu_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        sram_we     = 1'b0;
        tag_flags   = 2'b00;
        sram_data_o = store_line;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (sram_hit_i) begin
                        if (is_store) begin
                            sram_we   = 1'b1;
                            tag_flags = 2'b11;
                        end
                    end else begin
                        state_d = MISS;
                    end
                end
            end
            MISS:       state_d = (victim_valid && victim_dirty) ? WRITEBACK : READMISS;
            WRITEBACK:  if (mem_ack_i) state_d = READMISS;
            READMISS: begin
                if (mem_ack_i) begin
                    sram_we     = 1'b1;
                    tag_flags   = 2'b10;
                    sram_data_o = mem_data_i;
                    state_d     = READMISSOK;
                end
            end
            READMISSOK: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Memory request registers: launched from MISS, retargeted after write-back.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state_q)
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (victim_valid && victim_dirty) begin
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= wb_addr;
                        mem_data_o  <= sram_data_i;
                    end else begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= refill_addr;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= refill_addr;
                    end
                end
                READMISS: begin
                    if (mem_ack_i) mem_enable_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
